// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the second-generation memory interface unit.
package mem_if_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, REQ, DONE} mem_if_state_t;

  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

  // Address bits that select a byte lane inside one memory word.
  function automatic int unsigned lane_bits(input int unsigned mem_w);
    return $clog2(mem_w / 8);
  endfunction

endpackage

// File: rtl/mem_if_unit_v2_if.sv
// Command, write-data and SMM handshake bundle of the memory interface unit.
interface mem_if_unit_v2_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned MEM_W  = 16
);
  logic                 load;
  logic                 store;
  logic                 op_word;
  logic [ADDR_W-1:0]    addr;
  logic [MEM_W-1:0]     result;
  logic [MEM_W-1:0]     datafrommem;
  logic                 mem_resp;
  logic [ADDR_W-1:0]    addrout;
  logic [MEM_W-1:0]     datatomem;
  logic [MEM_W/8-1:0]   byte_en;
  logic                 read_req;
  logic                 write_req;
  logic                 cs;
  logic [MEM_W-1:0]     datatoinst;
  logic                 mem_done;
  logic                 mem_err;
  logic                 busy;

  modport slave (
    input  load, store, op_word, addr, result, datafrommem, mem_resp,
    output addrout, datatomem, byte_en, read_req, write_req, cs, datatoinst,
           mem_done, mem_err, busy
  );

  modport master (
    output load, store, op_word, addr, result, datafrommem, mem_resp,
    input  addrout, datatomem, byte_en, read_req, write_req, cs, datatoinst,
           mem_done, mem_err, busy
  );
endinterface

// File: rtl/mem_if_timer.sv
// Loadable saturating down-counter; load_i presets it to Max, zero_o flags a count of 0.
module mem_if_timer #(
  parameter int unsigned Max   = 1,
  parameter int unsigned Width = (Max < 1) ? 1 : $clog2(Max + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Width'(Max);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_if_unit_v2.sv
// Memory interface unit: turns load/store commands into one SMM read or write request
// with setup delay, byte enables, lane-selected read data and a response timeout.
module mem_if_unit_v2
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MEM_W     = 16,
  parameter int unsigned REQ_DELAY = 2,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             reset,
  mem_if_unit_v2_if.slave  bus
);
  localparam int unsigned LB = lane_bits(MEM_W);
  localparam int unsigned NB = MEM_W / 8;

  mem_if_state_t    state_d, state_q;
  mem_op_t          op_d, op_q;
  logic             word_d, word_q;
  logic [LB-1:0]    lane_d, lane_q;
  logic [ADDR_W-1:0] addrout_d, addrout_q;
  logic [MEM_W-1:0] datatomem_d, datatomem_q;
  logic [NB-1:0]    byte_en_d, byte_en_q;
  logic             read_req_d, read_req_q;
  logic             write_req_d, write_req_q;
  logic [MEM_W-1:0] datatoinst_d, datatoinst_q;
  logic             mem_done_d, mem_done_q;
  logic             mem_err_d, mem_err_q;
  logic             setup_zero, tmo_zero;
  logic [LB-1:0]    cmd_lane;

  // Timers are preset outside their state and count down inside it; the last cycle is at zero.
  mem_if_timer #(
    .Max ((REQ_DELAY > 0) ? REQ_DELAY - 1 : 0)
  ) u_setup_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (state_q != SETUP),
    .dec_i  (state_q == SETUP),
    .zero_o (setup_zero)
  );

  mem_if_timer #(
    .Max (TIMEOUT - 1)
  ) u_tmo_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (state_q != REQ),
    .dec_i  ((state_q == REQ) && !bus.mem_resp),
    .zero_o (tmo_zero)
  );

  assign cmd_lane = bus.addr[LB-1:0];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    word_d       = word_q;
    lane_d       = lane_q;
    addrout_d    = addrout_q;
    datatomem_d  = datatomem_q;
    byte_en_d    = byte_en_q;
    read_req_d   = read_req_q;
    write_req_d  = write_req_q;
    datatoinst_d = datatoinst_q;
    mem_done_d   = 1'b0;
    mem_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load && bus.store) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
          mem_err_d  = 1'b1;
        end else if (bus.load || bus.store) begin
          if (bus.op_word && (cmd_lane != '0)) begin
            state_d    = DONE;
            mem_done_d = 1'b1;
            mem_err_d  = 1'b1;
          end else begin
            op_d      = bus.store ? OP_WRITE : OP_READ;
            word_d    = bus.op_word;
            lane_d    = cmd_lane;
            addrout_d = {bus.addr[ADDR_W-1:LB], {LB{1'b0}}};
            if (bus.store) begin
              datatomem_d = bus.op_word ? bus.result : {NB{bus.result[7:0]}};
              byte_en_d   = bus.op_word ? '1 : (NB'(1) << cmd_lane);
            end else begin
              datatomem_d = '0;
              byte_en_d   = '0;
            end
            if (REQ_DELAY == 0) begin
              state_d     = REQ;
              read_req_d  = !bus.store;
              write_req_d = bus.store;
            end else begin
              state_d = SETUP;
            end
          end
        end
      end
      SETUP: begin
        if (setup_zero) begin
          state_d     = REQ;
          read_req_d  = (op_q == OP_READ);
          write_req_d = (op_q == OP_WRITE);
        end
      end
      REQ: begin
        if (bus.mem_resp) begin
          state_d     = DONE;
          read_req_d  = 1'b0;
          write_req_d = 1'b0;
          mem_done_d  = 1'b1;
          if (op_q == OP_READ) begin
            datatoinst_d = word_q ? bus.datafrommem
                                  : {{(MEM_W-8){1'b0}}, bus.datafrommem[{lane_q, 3'b000} +: 8]};
          end
        end else if (tmo_zero) begin
          state_d     = DONE;
          read_req_d  = 1'b0;
          write_req_d = 1'b0;
          mem_done_d  = 1'b1;
          mem_err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_READ;
      word_q       <= 1'b0;
      lane_q       <= '0;
      addrout_q    <= '0;
      datatomem_q  <= '0;
      byte_en_q    <= '0;
      read_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      datatoinst_q <= '0;
      mem_done_q   <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      word_q       <= word_d;
      lane_q       <= lane_d;
      addrout_q    <= addrout_d;
      datatomem_q  <= datatomem_d;
      byte_en_q    <= byte_en_d;
      read_req_q   <= read_req_d;
      write_req_q  <= write_req_d;
      datatoinst_q <= datatoinst_d;
      mem_done_q   <= mem_done_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign bus.addrout    = addrout_q;
  assign bus.datatomem  = datatomem_q;
  assign bus.byte_en    = byte_en_q;
  assign bus.read_req   = read_req_q;
  assign bus.write_req  = write_req_q;
  assign bus.cs         = read_req_q | write_req_q;
  assign bus.datatoinst = datatoinst_q;
  assign bus.mem_done   = mem_done_q;
  assign bus.mem_err    = mem_err_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/mem_if_unit_v2.md
Name: mem_if_unit_v2

Overview:
- Parametrised second-generation memory interface between the instruction unit and the system memory model (SMM).
- Turns load/store commands into a single read or write request with a programmable setup delay, per-byte write enables and sub-word read lane selection.
- Adds a response timeout with an error report.
- Output is one mem_done pulse per command, with mem_err qualifying it.

Parameters:
ADDR_W, 14, byte address width (16 KB space)
MEM_W, 16, memory data width in bits; multiple of 8, at least 16
REQ_DELAY, 2, cycles between command accept and request assertion (0 allowed)
TIMEOUT, 15, maximum cycles the request stays high waiting for mem_resp; at least 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
load  in  1  read command, level, from instruction unit
store  in  1  write command, level, from instruction unit
op_word  in  1  0 = byte access, 1 = full MEM_W word access
addr  in  ADDR_W  byte address
result  in  MEM_W  store data; byte stores use bits [7:0]
datafrommem  in  MEM_W  read data from SMM
mem_resp  in  1  SMM response, valid while a request is high
addrout  out  ADDR_W  word-aligned address to SMM (lane bits zeroed)
datatomem  out  MEM_W  write data to SMM, replicated into the selected lane
byte_en  out  MEM_W/8  write byte enables
read_req  out  1  read request
write_req  out  1  write request
cs  out  1  read_req OR write_req (combinational)
datatoinst  out  MEM_W  read data, zero-extended for byte reads
mem_done  out  1  one-cycle completion pulse
mem_err  out  1  valid only with mem_done; 1 = access failed
busy  out  1  high in every state except IDLE

Behaviour:
- Reset value 0 for every registered output; FSM goes to IDLE. Assertion takes effect immediately and is asynchronous.
- Reset mid-access drops read_req and write_req at once. No mem_done is produced for the aborted access.
- FSM states: IDLE, SETUP, REQ, DONE.
- IDLE, command check:
  - Commands are sampled only in IDLE.
  - load and store both high: illegal. Go to DONE with mem_err=1; no request is issued.
  - op_word=1 with addr[$clog2(MEM_W/8)-1:0] != 0: misaligned. Go to DONE with mem_err=1; no request is issued.
- IDLE, legal command:
  - Latch opcode, size and lane.
  - Drive addrout, datatomem and byte_en from the next cycle.
  - Go to SETUP, or straight to REQ when REQ_DELAY=0.
- SETUP: a counter runs REQ_DELAY cycles, then the FSM enters REQ. addrout, datatomem and byte_en are stable from SETUP until leaving REQ.
- REQ, request and timeout:
  - read_req or write_req is high.
  - A timeout counter starts at 0 on entry and increments each cycle mem_resp is low.
- REQ, response:
  - mem_resp high in REQ: request drops on the next edge and the FSM goes to DONE with mem_err=0.
  - Reads capture datatoinst on that same edge: byte lane addr[lane] is zero-extended, or the full word for word reads.
- REQ, timeout: counter reaches TIMEOUT with no response. Request drops and the FSM goes to DONE with mem_err=1. datatoinst is unchanged.
- DONE: mem_done=1 for exactly one cycle, then IDLE.
  - The instruction unit must drop load/store in the DONE cycle.
  - If the command is still high in IDLE, a new access starts; this is intended for back-to-back operation.
- Latency, successful access: the request is first high at cycle REQ_DELAY+1 after the accept edge. mem_done is high 1 cycle after the edge that samples mem_resp.
- Ignored inputs:
  - mem_resp outside REQ.
  - load/store changes outside IDLE; the command is latched.
- Write data and enables:
  - byte_en for a byte store is a one-hot lane; for a word store it is all ones. It is 0 for reads.
  - datatomem for a byte store replicates result[7:0] into every lane.
- Counters saturate and never wrap; widths are $clog2(max+1).

Decomposition:
- Package mem_if_pkg holds:
  - typedef enum logic [1:0] mem_if_state_t {IDLE, SETUP, REQ, DONE}
  - typedef enum logic {OP_READ, OP_WRITE} mem_op_t
  - localparam function lane_bits(MEM_W)
- Sub-module mem_if_timer: a loadable saturating down-counter with a zero flag. It is used twice, once for the SETUP delay and once for the REQ timeout.

Test Plan:
- Byte load, addr=14'h0005, REQ_DELAY=2, SMM responds 3 cycles after read_req with 16'hA55A -> read_req high at cycle 3; addrout=14'h0004; datatoinst=16'h00A5; mem_done=1, mem_err=0, exactly once.
- Word store, addr=14'h0010, result=16'h1234, immediate response -> write_req high 1 cycle; byte_en=2'b11; datatomem=16'h1234; mem_done a cycle later.
- Byte store, addr=14'h0003, result=16'hBEEF -> byte_en=2'b10; datatomem=16'hEFEF.
- No mem_resp, TIMEOUT=15 -> read_req high exactly 15 cycles, then mem_done=1 with mem_err=1; datatoinst keeps its prior value.
- Illegal commands -> load and store together, and word access at odd addr 14'h0007, each give mem_done+mem_err 1 cycle after accept, with read_req and write_req never high.
- Reset asserted asynchronously in the middle of REQ -> all outputs 0 before the next clk edge, then a new load completes normally; also check REQ_DELAY=0 and MEM_W=32 builds.
